// File: rtl/ext_call_pkg.sv
// Shared types and widths for the external-entry call issuer.
package ext_call_pkg;

  localparam int EXT_ARG_W  = 32;
  localparam int EXT_RES_W  = 64;
  localparam int EXT_PAIR_W = 2 * EXT_ARG_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RES,
    ST_OUT
  } state_e;

endpackage

// File: rtl/ext_call_pair_fifo.sv
// DEPTH x 64 FIFO of {arg0, arg1} pairs; wrap-bit pointers decode full/empty.
module ext_call_pair_fifo
  import ext_call_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [EXT_PAIR_W-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [EXT_PAIR_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [EXT_PAIR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers
  // define which entries are valid, and a reset net on the array buys nothing.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ext_call_issuer.sv
// Pairs argument words into calls, issues them one at a time to an external
// entry and registers each result. Optional counters under EXT_CALL_PERF_EN.
module ext_call_issuer
  import ext_call_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXT_ARG_W-1:0] in_data,
  output logic                 f_req_valid,
  input  logic                 f_req_ready,
  input  logic                 f_req_busy,
  output logic [EXT_ARG_W-1:0] f_req_0,
  output logic [EXT_ARG_W-1:0] f_req_1,
  input  logic                 f_res_valid,
  output logic                 f_res_ready,
  input  logic [EXT_RES_W-1:0] f_res_0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXT_RES_W-1:0] out_data,
`ifdef EXT_CALL_PERF_EN
  output logic [31:0]          perf_calls,
  output logic [31:0]          perf_wait,
`endif
  output logic                 busy
);

  state_e                state, state_d;
  logic                  half;
  logic [EXT_ARG_W-1:0]  held;
  logic                  accept, push, pop;
  logic                  fifo_full, fifo_empty;
  logic [EXT_PAIR_W-1:0] fifo_head;

  logic                  req_valid_d, res_ready_d, out_valid_d;
  logic [EXT_ARG_W-1:0]  req0_d, req1_d;
  logic [EXT_RES_W-1:0]  out_data_d;

  // Entry busy is informational only; the handshakes carry all flow control.
  logic unused_req_busy;
  assign unused_req_busy = f_req_busy;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && half;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half <= 1'b0;
      held <= '0;
    end else if (accept) begin
      if (!half) begin
        held <= in_data;
        half <= 1'b1;
      end else begin
        half <= 1'b0;
      end
    end
  end

  ext_call_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({held, in_data}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d     = state;
    req_valid_d = f_req_valid;
    req0_d      = f_req_0;
    req1_d      = f_req_1;
    res_ready_d = f_res_ready;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    pop         = 1'b0;
    unique case (state)
      ST_IDLE: if (!fifo_empty) begin
        req0_d      = fifo_head[EXT_PAIR_W-1 -: EXT_ARG_W];
        req1_d      = fifo_head[EXT_ARG_W-1:0];
        req_valid_d = 1'b1;
        state_d     = ST_REQ;
      end
      ST_REQ: if (f_req_ready) begin
        // The pair stays in the FIFO until the entry takes it.
        pop         = 1'b1;
        req_valid_d = 1'b0;
        res_ready_d = 1'b1;
        state_d     = ST_RES;
      end
      ST_RES: if (f_res_valid) begin
        out_data_d  = f_res_0;
        out_valid_d = 1'b1;
        res_ready_d = 1'b0;
        state_d     = ST_OUT;
      end
      ST_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      f_req_valid <= 1'b0;
      f_req_0     <= '0;
      f_req_1     <= '0;
      f_res_ready <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state       <= state_d;
      f_req_valid <= req_valid_d;
      f_req_0     <= req0_d;
      f_req_1     <= req1_d;
      f_res_ready <= res_ready_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
    end
  end

  assign busy = half || !fifo_empty || (state != ST_IDLE);

`ifdef EXT_CALL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_calls <= '0;
      perf_wait  <= '0;
    end else if (state == ST_RES) begin
      if (f_res_valid) perf_calls <= perf_calls + 32'd1;
      else             perf_wait  <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ext_call_issuer.sv
// Directed bench for ext_call_issuer with a 3-cycle callee model that echoes {arg0, arg1}.
module tb_ext_call_issuer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        f_req_valid, f_req_ready, f_req_busy;
  logic [31:0] f_req_0, f_req_1;
  logic        f_res_valid, f_res_ready;
  logic [63:0] f_res_0;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        busy;
`ifdef EXT_CALL_PERF_EN
  logic [31:0] perf_calls, perf_wait;
`endif

  int checks   = 0;
  int failures = 0;
  logic callee_en = 1'b0;

  always #5 clk = ~clk;

  ext_call_issuer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_req_busy  (f_req_busy),
    .f_req_0     (f_req_0),
    .f_req_1     (f_req_1),
    .f_res_valid (f_res_valid),
    .f_res_ready (f_res_ready),
    .f_res_0     (f_res_0),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef EXT_CALL_PERF_EN
    .perf_calls  (perf_calls),
    .perf_wait   (perf_wait),
`endif
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Callee: one-cycle ready pulse, three cycles of no result, then result for one cycle.
  initial begin : callee
    int cst = 0;
    int cnt = 0;
    logic [31:0] a0 = '0;
    logic [31:0] a1 = '0;
    f_req_ready = 1'b0;
    f_req_busy  = 1'b0;
    f_res_valid = 1'b0;
    f_res_0     = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cst = 0; f_req_ready = 1'b0; f_res_valid = 1'b0; f_req_busy = 1'b0;
      end else begin
        case (cst)
          0: if (callee_en && f_req_valid) begin
            a0 = f_req_0; a1 = f_req_1; f_req_ready = 1'b1; cst = 1;
          end
          1: begin f_req_ready = 1'b0; f_req_busy = 1'b1; cnt = 0; cst = 2; end
          2: begin
            cnt++;
            if (cnt == 3) begin f_res_valid = 1'b1; f_res_0 = {a0, a1}; cst = 3; end
          end
          default: begin f_res_valid = 1'b0; f_req_busy = 1'b0; cst = 0; end
        endcase
      end
    end
  end

  // All main-thread tasks start and end just after a falling edge.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n == 200) check("send_timeout", 64'(w), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] exp);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready), 64'd1);
    check({tag, "_req_valid"}, 64'(f_req_valid), 64'd0);
    check({tag, "_req_args"},  {f_req_0, f_req_1}, 64'd0);
    check({tag, "_res_ready"}, 64'(f_res_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  out_data, 64'd0);
    check({tag, "_busy"},      64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic seen_req;
    int n;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic call: words 1, 2 with request latency
    callee_en = 1'b1;
    send_word(32'd1);
    send_word(32'd2);
    check("t1_req_not_yet", 64'(f_req_valid), 64'd0);
    @(negedge clk);
    check("t1_req_valid", 64'(f_req_valid), 64'd1);
    check("t1_req_args", {f_req_0, f_req_1}, 64'h0000_0001_0000_0002);
    wait_out("t1_out", 64'h0000_0001_0000_0002);
    check("t1_busy_low", 64'(busy), 64'd0);

    // FIFO fill with stalled callee
    callee_en = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) send_word(32'(10 + i));
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; in_data = 32'd18;
    repeat (5) @(negedge clk);
    check("t2_still_full", 64'(in_ready), 64'd0);
    check("t2_req_held", {f_req_0, f_req_1}, 64'h0000_000A_0000_000B);
    callee_en = 1'b1;
    send_word(32'd18);
    send_word(32'd19);
    for (int i = 0; i < DEPTH + 1; i++)
      wait_out("t2_out", {32'(10 + 2 * i), 32'(11 + 2 * i)});
    check("t2_busy_low", 64'(busy), 64'd0);

    // Downstream stall holds output and blocks the next request
    for (int i = 0; i < 4; i++) send_word(32'(20 + i));
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_data", out_data, 64'h0000_0014_0000_0015);
      check("t3_no_req", 64'(f_req_valid), 64'd0);
      @(negedge clk);
    end
    wait_out("t3_out0", 64'h0000_0014_0000_0015);
    wait_out("t3_out1", 64'h0000_0016_0000_0017);

    // Lone half word is held without issuing
    send_word(32'd7);
    seen_req = 1'b0;
    repeat (20) begin @(negedge clk); seen_req |= f_req_valid; end
    check("t4_no_req", 64'(seen_req), 64'd0);
    check("t4_busy_half", 64'(busy), 64'd1);
    send_word(32'd8);
    wait_out("t4_out", 64'h0000_0007_0000_0008);

    // Reset in RES aborts the call and flushes buffered pairs and half word
    for (int i = 0; i < 5; i++) send_word(32'(30 + i));
    n = 0;
    while (!f_res_ready && n < 200) begin @(negedge clk); n++; end
    check("t5_in_res", 64'(f_res_ready), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word(32'd40);
    send_word(32'd41);
    wait_out("t5_out", 64'h0000_0028_0000_0029);
    check("t5_busy_low", 64'(busy), 64'd0);

`ifdef EXT_CALL_PERF_EN
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_perf_reset", {perf_calls, perf_wait}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      send_word(32'(50 + 2 * i));
      send_word(32'(51 + 2 * i));
      wait_out("t6_out", {32'(50 + 2 * i), 32'(51 + 2 * i)});
    end
    check("t6_perf_calls", 64'(perf_calls), 64'd3);
    check("t6_perf_wait", 64'(perf_wait), 64'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_call_issuer.md
# ext_call_issuer

Upstream feeder for a synthesized external entry method (`f_req_*` / `f_res_*` port group). Accepts a stream of 32-bit argument words, pairs them into `{arg0, arg1}` calls and buffers them in a small FIFO. Issues one call at a time over the entry's req/res handshakes and forwards each 64-bit result to a downstream valid/ready consumer. Sits between a host-side word stream and the generated module's external entry.

## Interface
- `DEPTH`, 4: argument-pair FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `in_valid` in 1: argument word valid.
- `in_ready` out 1: argument word accepted when `in_valid && in_ready`.
- `in_data` in 32: argument word; even-numbered words are arg0, odd-numbered words are arg1.
- `f_req_valid` out 1: call request to the entry.
- `f_req_ready` in 1: entry accepted the request.
- `f_req_busy` in 1: entry is executing; status only.
- `f_req_0` out 32: arg0 of the current call.
- `f_req_1` out 32: arg1 of the current call.
- `f_res_valid` in 1: entry result valid.
- `f_res_ready` out 1: issuer ready to take the result.
- `f_res_0` in 64: entry result.
- `out_valid` out 1: result available downstream.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 64: registered result.
- `busy` out 1: high if any of the following holds: a half-pair is pending, the FIFO is non-empty, or the FSM is not IDLE.

## Operation
- **Pairing:**
  - `half` flag plus a 32-bit `arg0` holding register.
  - On an accepted word with `half==0`, store it in the holding register and set `half`.
  - On an accepted word with `half==1`, push `{held, in_data}` into the FIFO and clear `half`.
- `in_ready = !fifo_full`, evaluated identically for both halves. A pending half word is held indefinitely; it is never timed out or flushed.
- FIFO: DEPTH×64, pointers carry an extra wrap bit; full and empty are decoded from the pointer MSB comparison.
- **FSM states:**
  - IDLE: if the FIFO is non-empty, load `f_req_0`/`f_req_1` from the head entry, set `f_req_valid=1`, go to REQ.
  - REQ: hold valid and data stable. When `f_req_ready` is sampled high: pop the FIFO, drop `f_req_valid`, set `f_res_ready=1`, go to RES.
  - RES: when `f_res_valid` is sampled high: `out_data<=f_res_0`, `out_valid<=1`, `f_res_ready<=0`, go to OUT.
  - OUT: when `out_valid && out_ready`: `out_valid<=0`, go to IDLE.
- At most one call is outstanding. Results leave in call order.
- A simultaneous FIFO push and pop in the same cycle is legal; the count is unchanged.
- **Reset values:**
  - All outputs are 0, except `in_ready=1`.
  - FIFO empty, `half=0`, FSM in IDLE.
  - Reset asserted mid-call aborts the call and drops buffered pairs and any pending half.

## Timing
- All outputs are registered, except `in_ready` (decoded from registered pointers) and `busy`.
- From the pushing word's accept edge to `f_req_valid` high: 2 cycles (push, then IDLE load).
- From sampling `f_req_ready` to `f_res_ready` high: next cycle.
- From sampling `f_res_valid` to `out_valid`: next cycle.
- Back-to-back calls are separated by at least one IDLE cycle.
- Input throughput is 1 word per cycle until the FIFO is full.

## Configuration
- `EXT_CALL_PERF_EN` defined:
  - Adds outputs `perf_calls` out 32, incremented per completed result capture.
  - Adds `perf_wait` out 32, incremented each cycle in RES with `f_res_valid` low.
  - Both reset to 0 and wrap modulo 2^32.
- `EXT_CALL_PERF_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `ext_call_pkg`:
  - State enum (IDLE, REQ, RES, OUT).
  - `EXT_ARG_W=32` and `EXT_RES_W=64`.
- Sub-module `ext_call_pair_fifo`: DEPTH×64 FIFO with push, pop, full, empty and head data. The top holds the pairing logic, FSM and output register.

## Test plan
Use a callee model that returns `{arg0,arg1}` after 3 cycles and asserts `f_req_ready` for 1 cycle.
- Words 1, 2 → `f_req_0=1`, `f_req_1=2`, then `out_data=64'h0000000100000002`; `busy` goes low after `out_ready` is seen.
- Stream of 2·DEPTH+2 words with the callee stalled → `in_ready` drops when the FIFO is full. After release, DEPTH+1 results arrive in order.
- `out_ready` held low for 10 cycles → `out_valid` and `out_data` stay stable, and no new `f_req_valid` is raised.
- Single word 7 followed by 20 idle cycles → no request is issued. Word 8 then yields `out_data=64'h0000000700000008`.
- Reset asserted while in RES → all outputs return to reset values within the assert edge; after release, a new pair of words completes normally.
- With `EXT_CALL_PERF_EN`: 3 calls with a 3-cycle callee → `perf_calls=3`, `perf_wait=9`.
